fixed_point_divider: RTL

- Sequential signed fixed-point divider for the ODE accelerator arithmetic library. It computes result = A / B on Q(WIDTH-FRAC).FRAC two's-complement operands.
- Produces one quotient bit per clock using restoring division on operand magnitudes. It performs the inverse operation that feeds into the datapath alongside the adder and multiplier.
- Flag outputs (overflow_flag, negative) match the adder's flag semantics, so downstream logic treats both units uniformly.
- Start/done handshake; one division in flight at a time.

---
 rtl/fixed_point_divider.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: restoring division on magnitudes, one quotient bit
// per clock, with saturation and divide-by-zero flags.
module fixed_point_divider #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow_flag,
  output logic             divide_by_zero,
  output logic             negative
);

  localparam int unsigned QW = WIDTH + FRAC;
  localparam int unsigned CW = $clog2(QW);

  localparam logic [QW-1:0]    NegLim = QW'(1) << (WIDTH - 1);
  localparam logic [QW-1:0]    PosLim = NegLim - QW'(1);
  localparam logic [WIDTH-1:0] ResMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ResMin = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StDiv, StFinish} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [QW-1:0]    dq_q, dq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] amag, bmag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             q_bit;
  logic [QW-1:0]    dq_step;
  logic [WIDTH-1:0] sat_result;
  logic             sat_ovf;

  assign amag = A[WIDTH-1] ? -A : A;
  assign bmag = B[WIDTH-1] ? -B : B;

  // Dividend bits leave the top of dq while quotient bits enter at the bottom.
  assign rem_shift = {rem_q, dq_q[QW-1]};
  assign q_bit     = rem_shift >= {1'b0, bmag_q};
  assign rem_sub   = rem_shift[WIDTH-1:0] - bmag_q;
  assign dq_step   = {dq_q[QW-2:0], q_bit};

  always_comb begin
    sat_result = sign_q ? -dq_step[WIDTH-1:0] : dq_step[WIDTH-1:0];
    sat_ovf    = 1'b0;
    if (!sign_q && (dq_step > PosLim)) begin
      sat_result = ResMax;
      sat_ovf    = 1'b1;
    end else if (sign_q && (dq_step > NegLim)) begin
      sat_result = ResMin;
      sat_ovf    = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    bmag_d   = bmag_q;
    rem_d    = rem_q;
    dq_d     = dq_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d = A[WIDTH-1] ^ B[WIDTH-1];
          bmag_d = bmag;
          rem_d  = '0;
          dq_d   = QW'(amag) << FRAC;
          cnt_d  = CW'(QW - 1);
          if (B == '0) begin
            result_d = A[WIDTH-1] ? ResMin : ResMax;
            ovf_d    = 1'b0;
            dbz_d    = 1'b1;
            state_d  = StFinish;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        rem_d = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
        dq_d  = dq_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // Result and flags are captured on entry so they are valid while done is high.
          result_d = sat_result;
          ovf_d    = sat_ovf;
          dbz_d    = 1'b0;
          state_d  = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      bmag_q   <= '0;
      rem_q    <= '0;
      dq_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      bmag_q   <= bmag_d;
      rem_q    <= rem_d;
      dq_q     <= dq_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result         = result_q;
  assign done           = (state_q == StFinish);
  assign busy           = (state_q != StIdle);
  assign overflow_flag  = ovf_q;
  assign divide_by_zero = dbz_q;
  assign negative       = result_q[WIDTH-1];

endmodule
